quad_rate_meter: RTL and testbench
==================================

# quad_rate_meter

Quadrature rate meter for one encoder channel in the TinyQV encoder peripheral. Sits directly downstream of the per-pin debouncers, in parallel with the position counters. It consumes one debounced A/B pair, decodes x4 quadrature steps and accumulates a signed step count over a programmable window of clock cycles. At each window end it publishes that count as a signed rate with a one-cycle valid strobe, plus sticky illegal-transition and saturation flags for the register file.

## Interface
- WINDOW_W, 16: width of window counter and `window_cmp`.
- RATE_W, 8: width of signed accumulator and `rate` output (two's complement).

- clk  in  1  project clock (64 MHz nominal).
- rst_n  in  1  reset; one clock, synchronous, active-low.
- a  in  1  debounced quadrature A, already synchronous to clk.
- b  in  1  debounced quadrature B, already synchronous to clk.
- window_cmp  in  WINDOW_W  window length minus 1, in clk cycles; sampled every cycle.
- clear  in  1  single-cycle software clear of counters, flags and `rate`.
- rate  out  RATE_W  signed step count of the last completed window.
- rate_valid  out  1  one-cycle pulse when `rate` is updated.
- dir  out  1  direction of last legal step: 1 = forward, 0 = reverse.
- err_sticky  out  1  set on any illegal (double-bit) transition.
- sat_sticky  out  1  set when the accumulator clamps.

## Operation
- State: `prev_ab[1:0]`, `primed`, `win_cnt[WINDOW_W-1:0]`, `acc[RATE_W-1:0]`, plus output registers.
- Priming: first cycle after reset or `clear` loads `prev_ab <= {a,b}`, sets `primed`, counts nothing. This avoids a spurious step from the reset value.
- Step decode, with `cur = {a,b}` when primed:
  - Forward (+1): 00→01→11→10→00.
  - Reverse (−1): the opposite order.
  - cur == prev: step 0.
  - Both bits change (00↔11, 01↔10): step 0, set `err_sticky`, leave `dir` unchanged.
  - `prev_ab <= cur` every primed cycle.
- Accumulate: `acc <= sat(acc + step)`.
  - Clamp to +2^(RATE_W-1)−1 and −2^(RATE_W-1).
  - Clamping sets `sat_sticky`.
- Window end: when `win_cnt >= window_cmp`:
  - `rate <= sat(acc + step)`, so a step on the final cycle belongs to this window.
  - `acc <= 0`, `win_cnt <= 0`, `rate_valid <= 1`.
  - Otherwise `win_cnt <= win_cnt + 1`, `rate_valid <= 0`.
  - The window counter never wraps.
- `window_cmp` = 0: window end every cycle, `rate` = step of that cycle.
- `window_cmp` lowered below `win_cnt` mid-window: window ends on the next cycle (>= compare).
- `dir` updates on every legal nonzero step.
- `clear`:
  - Zeroes `acc`, `win_cnt`, `rate`, both sticky flags and `rate_valid`.
  - Clears `primed`.
  - Wins over a coincident window end; no `rate_valid` is issued.
- Flags stay set until `clear` or reset; a new event in the same cycle as `clear` is dropped.

## Timing
- Reset values: `rate` = 0, `rate_valid` = 0, `dir` = 0, `err_sticky` = 0, `sat_sticky` = 0; internally `primed` = 0, `acc` = 0, `win_cnt` = 0.
- Input change sampled at edge k updates `acc`, `dir` and flags at edge k.
- A window opened at edge with `win_cnt` = 0 closes `window_cmp`+1 cycles later.
  - `rate` and `rate_valid` become visible after that edge (registered, zero added latency).
- `rate_valid` is high exactly one cycle per window and never two cycles back-to-back, except when `window_cmp` = 0.
- Reset mid-window discards the partial count; no `rate_valid` until a full window has elapsed after priming.
  - The window counter runs from the priming cycle.

## Structure
- Package `quad_pkg`:
  - Typedef `ab_t` (2-bit).
  - Step encoding constants STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR.
  - Function for saturating signed add parameterised on width.
- Sub-module `quad_step_decode`: combinational (prev_ab, cur_ab) → step/illegal, reusable by the position counters.
- Top `quad_rate_meter`: registers, window counter, saturating accumulator.

## Test plan
- `window_cmp` = 99, 10 forward steps spaced 5 cycles after priming → on cycle 100, `rate` = 0x0A, `rate_valid` high one cycle, `dir` = 1.
- Same window, 3 reverse steps → `rate` = 0xFD, `dir` = 0; next empty window → `rate` = 0x00.
- RATE_W = 8, `window_cmp` = 999, 200 forward steps → `rate` = 0x7F, `sat_sticky` = 1.
  - Then `clear` → `sat_sticky` = 0, `rate` = 0, no `rate_valid` that cycle.
- Illegal 00→11 → `err_sticky` = 1, `acc` unchanged, `dir` unchanged.
  - Subsequent legal steps still counted.
- `window_cmp` = 0, forward step each cycle → `rate` = 0x01 with `rate_valid` every cycle.
  - Step on the last cycle of a 10-cycle window is counted in that window.
- Reset asserted mid-window with `acc` = 5 → all outputs 0.
  - Inputs held at 11 through reset release produce no step on the priming cycle.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder peripheral.
package quad_pkg;

  // Debounced {a,b} pin pair.
  typedef logic [1:0] ab_t;

  // Step codes equal the quadrature phase difference (cur - prev) mod 4,
  // so the decoder can produce them with a single subtraction.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_ERR  = 2'd2,
    STEP_REV  = 2'd3
  } step_t;

  // Result of a saturating add: clamped value plus a flag saying it clamped.
  typedef struct packed {
    logic signed [31:0] value;
    logic               clamped;
  } sat_t;

  // Signed add of a and b, clamped to the two's complement range of `width`
  // bits (width <= 31).
  function automatic sat_t sat_add(input int a, input int b, input int width);
    sat_t r;
    int   sum;
    int   hi;
    int   lo;
    sum       = a + b;
    hi        = (1 <<< (width - 1)) - 1;
    lo        = -(1 <<< (width - 1));
    r.value   = sum;
    r.clamped = 1'b0;
    if (sum > hi) begin
      r.value   = hi;
      r.clamped = 1'b1;
    end else if (sum < lo) begin
      r.value   = lo;
      r.clamped = 1'b1;
    end
    return r;
  endfunction

  // Signed contribution of one decoded step to a count.
  function automatic int step_value(input step_t s);
    case (s)
      STEP_FWD: return 1;
      STEP_REV: return -1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decode.sv
// Combinational x4 quadrature decoder: previous/current {a,b} -> step code.
// Shared with the position counters.
module quad_step_decode
  import quad_pkg::*;
(
  input  ab_t   prev_ab,
  input  ab_t   cur_ab,
  output step_t step,
  output logic  illegal
);

  // Map the Gray sequence 00,01,11,10 onto phases 0,1,2,3.
  function automatic logic [1:0] phase(input ab_t x);
    return {x[1], x[1] ^ x[0]};
  endfunction

  logic [1:0] delta;

  // Phase difference mod 4: 0 hold, 1 forward, 3 reverse, 2 both bits flipped.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
    delta   = phase(cur_ab) - phase(prev_ab);
    step    = step_t'(delta);
    illegal = (step == STEP_ERR);
  end

endmodule

// File: rtl/quad_rate_meter.sv
// Quadrature rate meter: counts signed x4 steps over a programmable window
// and publishes the count with a one-cycle valid strobe and sticky flags.
module quad_rate_meter
  import quad_pkg::*;
#(
  parameter int WINDOW_W = 16,
  parameter int RATE_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a,
  input  logic                b,
  input  logic [WINDOW_W-1:0] window_cmp,
  input  logic                clear,
  output logic [RATE_W-1:0]   rate,
  output logic                rate_valid,
  output logic                dir,
  output logic                err_sticky,
  output logic                sat_sticky
);

  ab_t                      prev_ab;
  ab_t                      cur_ab;
  logic                     primed;
  logic [WINDOW_W-1:0]      win_cnt;
  logic signed [RATE_W-1:0] acc;

  step_t                    step;
  logic                     illegal;
  int                       step_val;
  sat_t                     acc_sum;
  logic [RATE_W-1:0]        acc_next;
  logic                     window_end;

  assign cur_ab = {a, b};

  quad_step_decode u_decode (
    .prev_ab (prev_ab),
    .cur_ab  (cur_ab),
    .step    (step),
    .illegal (illegal)
  );

  // Step contribution (zero while priming) and the saturated running count.
  always_comb begin
    step_val   = primed ? step_value(step) : 0;
    acc_sum    = sat_add(int'(acc), step_val, RATE_W);
    acc_next   = RATE_W'(acc_sum.value);
    window_end = (win_cnt >= window_cmp);
  end

  // State update: priming, direction/flags, accumulation and window close.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      prev_ab    <= '0;
      primed     <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      dir        <= 1'b0;
      err_sticky <= 1'b0;
      sat_sticky <= 1'b0;
    end else if (clear) begin
      // Clear beats a coincident window end and drops same-cycle events;
      // the next cycle re-primes from the live pins.
      primed     <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      rate       <= '0;
      rate_valid <= 1'b0;
      err_sticky <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      prev_ab <= cur_ab;
      primed  <= 1'b1;

      if (primed) begin
        if (step == STEP_FWD) dir <= 1'b1;
        if (step == STEP_REV) dir <= 1'b0;
        if (illegal) err_sticky <= 1'b1;
      end

      if (acc_sum.clamped) sat_sticky <= 1'b1;

      // win_cnt stops at window_cmp, so it can never wrap.
      if (window_end) begin
        rate       <= acc_next;
        acc        <= '0;
        win_cnt    <= '0;
        rate_valid <= 1'b1;
      end else begin
        acc        <= acc_next;
        win_cnt    <= win_cnt + WINDOW_W'(1);
        rate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_rate_meter.sv
// Directed bench for quad_rate_meter: inputs driven and outputs sampled on
// the falling edge, so each sample reflects the preceding rising edge.
module tb_quad_rate_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a;
  logic        b;
  logic [15:0] window_cmp;
  logic        clear;
  logic [7:0]  rate;
  logic        rate_valid;
  logic        dir;
  logic        err_sticky;
  logic        sat_sticky;

  int n_cmp  = 0;
  int n_fail = 0;
  int phase_idx = 0;  // position in the Gray sequence 00,01,11,10

  quad_rate_meter #(.WINDOW_W(16), .RATE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .window_cmp (window_cmp),
    .clear      (clear),
    .rate       (rate),
    .rate_valid (rate_valid),
    .dir        (dir),
    .err_sticky (err_sticky),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] gray(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic set_phase(input int i);
    phase_idx = i;
    {a, b} = gray(i);
  endtask

  // Run n cycles; step k (1..nsteps) is applied before cycle k*spacing.
  // Records how many rate_valid pulses appeared, the cycle of the last one
  // and the rate it carried.
  task automatic run(input int n, input int nsteps, input int spacing, input bit rev,
                     output int nvalid, output int last_idx, output logic [7:0] last_rate);
    nvalid    = 0;
    last_idx  = -1;
    last_rate = 8'hxx;
    for (int i = 1; i <= n; i++) begin
      if ((i % spacing) == 0 && (i / spacing) <= nsteps)
        set_phase(rev ? (phase_idx + 3) % 4 : (phase_idx + 1) % 4);
      @(negedge clk);
      if (rate_valid) begin
        nvalid++;
        last_idx  = i;
        last_rate = rate;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; window_cmp = 16'd99;
    set_phase(0);
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (rate !== 8'h00)      begin n_fail++; $display("FAIL reset_rate got=%h exp=00", rate); end
    if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rate_valid); end
    if (dir !== 1'b0)        begin n_fail++; $display("FAIL reset_dir got=%b exp=0", dir); end
    if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_sticky); end
    if (sat_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat_sticky); end
  endtask

  // Window 99: priming edge is cycle 1, window closes on cycle 100.
  task automatic test_forward();
    int nv, li; logic [7:0] lr;
    rst_n = 1'b1;
    run(101, 10, 5, 1'b0, nv, li, lr);
    n_cmp += 4;
    if (nv !== 1)      begin n_fail++; $display("FAIL fwd_pulses got=%0d exp=1", nv); end
    if (li !== 100)    begin n_fail++; $display("FAIL fwd_cycle got=%0d exp=100", li); end
    if (lr !== 8'h0A)  begin n_fail++; $display("FAIL fwd_rate got=%h exp=0a", lr); end
    if (dir !== 1'b1)  begin n_fail++; $display("FAIL fwd_dir got=%b exp=1", dir); end
  endtask

  // Cycle 101 above already opened the next window; 99 cycles remain.
  task automatic test_reverse();
    int nv, li; logic [7:0] lr;
    run(99, 3, 5, 1'b1, nv, li, lr);
    n_cmp += 4;
    if (nv !== 1 || li !== 99) begin n_fail++; $display("FAIL rev_pulse got=%0d@%0d exp=1@99", nv, li); end
    if (lr !== 8'hFD)  begin n_fail++; $display("FAIL rev_rate got=%h exp=fd", lr); end
    if (dir !== 1'b0)  begin n_fail++; $display("FAIL rev_dir got=%b exp=0", dir); end
    run(100, 0, 1, 1'b0, nv, li, lr);
    if (nv !== 1 || li !== 100 || lr !== 8'h00)
      begin n_fail++; $display("FAIL empty_window got=%0d@%0d rate=%h exp=1@100 rate=00", nv, li, lr); end
  endtask

  task automatic test_saturate_clear();
    int nv, li; logic [7:0] lr;
    window_cmp = 16'd999;
    run(1000, 200, 2, 1'b0, nv, li, lr);
    n_cmp += 6;
    if (nv !== 1 || li !== 1000) begin n_fail++; $display("FAIL sat_pulse got=%0d@%0d exp=1@1000", nv, li); end
    if (lr !== 8'h7F)       begin n_fail++; $display("FAIL sat_rate got=%h exp=7f", lr); end
    if (sat_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_flag got=%b exp=1", sat_sticky); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    if (sat_sticky !== 1'b0) begin n_fail++; $display("FAIL clear_sat got=%b exp=0", sat_sticky); end
    if (rate !== 8'h00)      begin n_fail++; $display("FAIL clear_rate got=%h exp=00", rate); end
    if (rate_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid got=%b exp=0", rate_valid); end
  endtask

  // 10-cycle window starting at the priming cycle after clear:
  // +1 -1 (illegal) +1 +1 +1 . . +1(last cycle) = 4.
  task automatic test_illegal();
    logic [1:0] seq [10];
    int nv = 0;
    logic [7:0] lr = 8'hxx;
    seq = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    window_cmp = 16'd9;
    n_cmp += 5;
    for (int i = 0; i < 10; i++) begin
      {a, b} = seq[i];
      @(negedge clk);
      if (rate_valid) begin nv++; lr = rate; end
      if (i == 3) begin
        if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_err got=%b exp=1", err_sticky); end
        if (dir !== 1'b0)        begin n_fail++; $display("FAIL ill_dir got=%b exp=0", dir); end
      end
    end
    phase_idx = 2;
    if (nv !== 1 || rate_valid !== 1'b1) begin n_fail++; $display("FAIL ill_pulse got=%0d last=%b exp=1 last=1", nv, rate_valid); end
    if (lr !== 8'h04)        begin n_fail++; $display("FAIL ill_rate got=%h exp=04", lr); end
    if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_err_hold got=%b exp=1", err_sticky); end
  endtask

  // Window of one cycle: every cycle publishes that cycle's step.
  task automatic test_back_to_back();
    window_cmp = 16'd0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_phase((phase_idx + 1) % 4);
      @(negedge clk);
      n_cmp++;
      if (rate_valid !== 1'b1 || rate !== ((i < 4) ? 8'h01 : 8'h00))
        begin n_fail++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, rate_valid, rate, (i < 4) ? 8'h01 : 8'h00); end
    end
    // Clear coincident with a window end and a step: no pulse, rate zero.
    clear = 1'b1;
    set_phase((phase_idx + 1) % 4);
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (rate_valid !== 1'b0 || rate !== 8'h00)
      begin n_fail++; $display("FAIL clear_win got=%b/%h exp=0/00", rate_valid, rate); end
    // Priming cycle: the pin change is absorbed, window closes with 0.
    set_phase((phase_idx + 1) % 4);
    @(negedge clk);
    n_cmp++;
    if (rate_valid !== 1'b1 || rate !== 8'h00)
      begin n_fail++; $display("FAIL prime_win got=%b/%h exp=1/00", rate_valid, rate); end
  endtask

  task automatic test_reset_mid_window();
    int nv, li; logic [7:0] lr;
    window_cmp = 16'd99;
    run(5, 5, 1, 1'b0, nv, li, lr);  // acc = 5, dir = 1
    rst_n = 1'b0;
    set_phase(2);                    // pins held at 11 through release
    @(negedge clk);
    n_cmp += 3;
    if (rate !== 8'h00 || rate_valid !== 1'b0 || dir !== 1'b0 || err_sticky !== 1'b0 || sat_sticky !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid got=%h/%b/%b/%b/%b exp=00/0/0/0/0", rate, rate_valid, dir, err_sticky, sat_sticky); end
    rst_n = 1'b1;
    run(100, 0, 1, 1'b0, nv, li, lr);
    if (nv !== 1 || li !== 100 || lr !== 8'h00)
      begin n_fail++; $display("FAIL rst_window got=%0d@%0d rate=%h exp=1@100 rate=00", nv, li, lr); end
    if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_prime_err got=%b exp=0", err_sticky); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_saturate_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
